// File: rtl/pipeline_controller.sv
// pipeline_controller: ID-stage hazard detection, branch flush control and
// SRAM access sequencing (IDLE/REQ/WAIT/DONE) with timeout and stall counting.
module pipeline_controller #(
  parameter int FORWARD_EN = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ID_RnIn,
  input  logic [3:0]  ID_Src2In,
  input  logic        ID_UsesRnIn,
  input  logic        ID_Two_srcIn,
  input  logic        EXE_WB_ENIn,
  input  logic        EXE_MEM_R_ENIn,
  input  logic        EXE_BIn,
  input  logic [3:0]  EXE_DestIn,
  input  logic        MEM_WB_ENIn,
  input  logic        MEM_R_ENIn,
  input  logic        MEM_W_ENIn,
  input  logic [3:0]  MEM_DestIn,
  input  logic        sramReadyIn,
  output logic        HazardOut,
  output logic        freezeOut,
  output logic        flushOut,
  output logic        sramStartOut,
  output logic        sramErrOut,
  output logic [15:0] stallCountOut
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [CW-1:0] cnt_r;
  logic          err_r;
  logic [15:0]   stall_r;

  logic match_exe_s;
  logic match_mem_s;
  logic raw_hazard_s;
  logic mem_req_s;
  logic timeout_s;
  logic freeze_s;
  logic start_s;
  logic flush_s;
  logic hazard_s;

  // Compare ID sources against EXE/MEM destinations; with forwarding only a load in EXE stalls
  always_comb begin
    match_exe_s = EXE_WB_ENIn & ((ID_UsesRnIn & (ID_RnIn == EXE_DestIn)) |
                                 (ID_Two_srcIn & (ID_Src2In == EXE_DestIn)));
    match_mem_s = MEM_WB_ENIn & ((ID_UsesRnIn & (ID_RnIn == MEM_DestIn)) |
                                 (ID_Two_srcIn & (ID_Src2In == MEM_DestIn)));
    if (FORWARD_EN != 0) begin
      raw_hazard_s = match_exe_s & EXE_MEM_R_ENIn;
    end else begin
      raw_hazard_s = match_exe_s | match_mem_s;
    end
  end

  assign mem_req_s = MEM_R_ENIn | MEM_W_ENIn;
  // A ready in the last allowed WAIT cycle wins over the timeout.
  assign timeout_s = (state_r == S_WAIT) & ~sramReadyIn & (cnt_r == CNT_LAST);

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; DONE always returns to IDLE so the finished access can advance
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (mem_req_s) begin
          next_state_s = S_REQ;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_REQ:  next_state_s = S_WAIT;
      S_WAIT: begin
        if (sramReadyIn || timeout_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output decode: freeze while an access is pending, flush/hazard suppressed by freeze
  always_comb begin
    freeze_s = 1'b0;
    start_s  = 1'b0;
    case (state_r)
      S_IDLE:  freeze_s = mem_req_s;
      S_REQ: begin
        freeze_s = 1'b1;
        start_s  = 1'b1;
      end
      S_WAIT:  freeze_s = 1'b1;
      S_DONE:  freeze_s = 1'b0;
      default: freeze_s = 1'b0;
    endcase
    flush_s  = EXE_BIn & ~freeze_s;
    hazard_s = raw_hazard_s & ~flush_s & ~freeze_s;
  end

  // WAIT-cycle counter, cleared on each new request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r == S_REQ) begin
      cnt_r <= {CW{1'b0}};
    end else if ((state_r == S_WAIT) && !sramReadyIn && !timeout_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky timeout error, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Saturating count of cycles spent stalled or frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_r <= 16'd0;
    end else if ((hazard_s || freeze_s) && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign HazardOut     = hazard_s;
  assign freezeOut     = freeze_s;
  assign flushOut      = flush_s;
  assign sramStartOut  = start_s;
  assign sramErrOut    = err_r;
  assign stallCountOut = stall_r;

endmodule

// File: tb/tb_pipeline_controller.sv
// Testbench for pipeline_controller: two instances (no forwarding / TIMEOUT 16,
// forwarding / TIMEOUT 4) driven by shared inputs and checked against a
// transaction-age reference model.
module tb_pipeline_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] id_rn, id_src2, exe_dest, mem_dest;
  logic       uses_rn, two_src, exe_wb, exe_rd, exe_b, mem_wb, mem_rd, mem_wr, ready;
  logic [1:0] haz, frz, fl, st, er;
  logic [1:0][15:0] sc;

  int checks = 0;
  int errors = 0;

  // reference model: age = -1 idle, 1 = request cycle, >=2 = waiting; rel = release cycle
  int age    [2];
  bit rel    [2];
  bit err_m  [2];
  int cnt_m  [2];
  int to_k   [2] = '{16, 4};
  int fwd_k  [2] = '{0, 1};

  pipeline_controller #(.FORWARD_EN(0), .TIMEOUT(16)) u0 (
    .clk(clk), .rst(rst), .ID_RnIn(id_rn), .ID_Src2In(id_src2),
    .ID_UsesRnIn(uses_rn), .ID_Two_srcIn(two_src), .EXE_WB_ENIn(exe_wb),
    .EXE_MEM_R_ENIn(exe_rd), .EXE_BIn(exe_b), .EXE_DestIn(exe_dest),
    .MEM_WB_ENIn(mem_wb), .MEM_R_ENIn(mem_rd), .MEM_W_ENIn(mem_wr),
    .MEM_DestIn(mem_dest), .sramReadyIn(ready), .HazardOut(haz[0]),
    .freezeOut(frz[0]), .flushOut(fl[0]), .sramStartOut(st[0]),
    .sramErrOut(er[0]), .stallCountOut(sc[0]));

  pipeline_controller #(.FORWARD_EN(1), .TIMEOUT(4)) u1 (
    .clk(clk), .rst(rst), .ID_RnIn(id_rn), .ID_Src2In(id_src2),
    .ID_UsesRnIn(uses_rn), .ID_Two_srcIn(two_src), .EXE_WB_ENIn(exe_wb),
    .EXE_MEM_R_ENIn(exe_rd), .EXE_BIn(exe_b), .EXE_DestIn(exe_dest),
    .MEM_WB_ENIn(mem_wb), .MEM_R_ENIn(mem_rd), .MEM_W_ENIn(mem_wr),
    .MEM_DestIn(mem_dest), .sramReadyIn(ready), .HazardOut(haz[1]),
    .freezeOut(frz[1]), .flushOut(fl[1]), .sramStartOut(st[1]),
    .sramErrOut(er[1]), .stallCountOut(sc[1]));

  function automatic bit m_match(input logic wb, input logic [3:0] d);
    return wb & ((uses_rn & (id_rn == d)) | (two_src & (id_src2 == d)));
  endfunction

  function automatic bit m_freeze(input int k);
    if (rel[k]) return 1'b0;
    if (age[k] < 0) return mem_rd | mem_wr;
    return 1'b1;
  endfunction

  function automatic bit m_start(input int k);
    return !rel[k] && (age[k] == 1);
  endfunction

  function automatic bit m_flush(input int k);
    return exe_b & !m_freeze(k);
  endfunction

  function automatic bit m_hazard(input int k);
    bit raw;
    if (fwd_k[k] != 0) raw = m_match(exe_wb, exe_dest) & exe_rd;
    else               raw = m_match(exe_wb, exe_dest) | m_match(mem_wb, mem_dest);
    return raw & !m_flush(k) & !m_freeze(k);
  endfunction

  function automatic void model_reset(input int k);
    age[k] = -1; rel[k] = 1'b0; err_m[k] = 1'b0; cnt_m[k] = 0;
  endfunction

  function automatic void advance(input int k);
    if (rel[k]) begin
      rel[k] = 1'b0; age[k] = -1;
    end else if (age[k] < 0) begin
      if (mem_rd | mem_wr) age[k] = 1;
    end else if (age[k] == 1) begin
      age[k] = 2;
    end else if (ready) begin
      rel[k] = 1'b1;
    end else if (age[k] - 2 == to_k[k] - 1) begin
      err_m[k] = 1'b1; rel[k] = 1'b1;
    end else begin
      age[k] = age[k] + 1;
    end
  endfunction

  task automatic zero_inputs();
    id_rn = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
    uses_rn = 1'b0; two_src = 1'b0; exe_wb = 1'b0; exe_rd = 1'b0; exe_b = 1'b0;
    mem_wb = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; ready = 1'b0;
  endtask

  // advance one clock, updating the model with the inputs held across the edge
  task automatic tick();
    bit busy [2];
    for (int k = 0; k < 2; k++) busy[k] = m_hazard(k) | m_freeze(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst) model_reset(k);
      else begin
        if (busy[k] && cnt_m[k] < 65535) cnt_m[k]++;
        advance(k);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    zero_inputs(); rst = 1'b0;
    for (int k = 0; k < 2; k++) model_reset(k);
    #3;
    checks++;
    if ({haz, fl, frz, st, er} !== 10'd0) begin errors++;
      $display("FAIL reset_flags: got %b expected 0", {haz, fl, frz, st, er}); end
    checks++;
    if (sc !== 32'd0) begin errors++; $display("FAIL reset_stall: got %h expected 0", sc); end
    exe_b = 1'b1; #1;
    checks++;
    if (fl !== 2'b11) begin errors++; $display("FAIL reset_flush_track: got %b expected 11", fl); end
    mem_rd = 1'b1; #1;
    checks++;
    if (frz !== 2'b11 || fl !== 2'b00) begin errors++;
      $display("FAIL reset_freeze_track: got frz=%b fl=%b expected 11/00", frz, fl); end
    zero_inputs();
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  task automatic test_hazard();
    zero_inputs();
    exe_dest = 4'd3; exe_wb = 1'b1; id_rn = 4'd3; uses_rn = 1'b1;
    @(negedge clk);
    checks++;
    if (haz !== 2'b01) begin errors++; $display("FAIL hazard_exe_match: got %b expected 01", haz); end
    tick();
    checks++;
    if (sc[0] !== 16'd1 || sc[1] !== 16'd0) begin errors++;
      $display("FAIL hazard_stall_count: got %0d/%0d expected 1/0", sc[0], sc[1]); end
  endtask

  task automatic test_forward();
    exe_rd = 1'b1;
    @(negedge clk);
    checks++;
    if (haz !== 2'b11) begin errors++; $display("FAIL forward_load_use: got %b expected 11", haz); end
    tick();
    zero_inputs();
    two_src = 1'b1; id_src2 = 4'd9; id_rn = 4'd5; mem_wb = 1'b1; mem_dest = 4'd9;
    @(negedge clk);
    checks++;
    if (haz !== 2'b01) begin errors++; $display("FAIL forward_mem_match: got %b expected 01", haz); end
    tick();
    checks++;
    if (sc[0] !== 16'd3 || sc[1] !== 16'd1) begin errors++;
      $display("FAIL forward_stall_count: got %0d/%0d expected 3/1", sc[0], sc[1]); end
  endtask

  task automatic test_latency();
    zero_inputs();
    for (int c = 0; c <= 6; c++) begin
      mem_rd = (c <= 5); ready = (c == 4);
      @(negedge clk);
      checks++;
      if (st !== ((c == 1) ? 2'b11 : 2'b00)) begin errors++;
        $display("FAIL latency_start c%0d: got %b expected %b", c, st, (c == 1) ? 2'b11 : 2'b00); end
      checks++;
      if (frz !== ((c <= 4) ? 2'b11 : 2'b00)) begin errors++;
        $display("FAIL latency_freeze c%0d: got %b expected %b", c, frz, (c <= 4) ? 2'b11 : 2'b00); end
      tick();
    end
  endtask

  task automatic test_flush();
    zero_inputs();
    exe_wb = 1'b1; exe_dest = 4'd3; id_rn = 4'd3; uses_rn = 1'b1; exe_rd = 1'b1; exe_b = 1'b1;
    @(negedge clk);
    checks++;
    if (fl !== 2'b11 || haz !== 2'b00) begin errors++;
      $display("FAIL flush_branch: got fl=%b haz=%b expected 11/00", fl, haz); end
    tick();
    for (int c = 0; c <= 3; c++) begin
      mem_wr = (c == 0); exe_b = (c == 2); ready = (c == 2);
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (fl !== 2'b00 || haz !== 2'b00 || frz !== 2'b11) begin errors++;
          $display("FAIL flush_in_wait: got fl=%b haz=%b frz=%b expected 00/00/11", fl, haz, frz); end
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    zero_inputs();
    for (int c = 0; c <= 24; c++) begin
      mem_wr = (c == 0);
      @(negedge clk);
      if (c == 5 || c == 17) begin
        checks++;
        if (frz[c == 5 ? 1 : 0] !== 1'b1 || er[c == 5 ? 1 : 0] !== 1'b0) begin errors++;
          $display("FAIL timeout_last_wait c%0d: got frz=%b er=%b expected 1/0", c, frz, er); end
      end
      if (c == 6 || c == 18) begin
        checks++;
        if (frz[c == 6 ? 1 : 0] !== 1'b0 || er[c == 6 ? 1 : 0] !== 1'b1) begin errors++;
          $display("FAIL timeout_done c%0d: got frz=%b er=%b expected 0/1", c, frz, er); end
      end
      if (c == 24) begin
        checks++;
        if (er !== 2'b11) begin errors++; $display("FAIL timeout_sticky: got %b expected 11", er); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      id_rn = 4'($urandom_range(0, 3)); id_src2 = 4'($urandom_range(0, 3));
      exe_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
      uses_rn = 1'($urandom_range(0, 1)); two_src = 1'($urandom_range(0, 1));
      exe_wb = 1'($urandom_range(0, 1)); exe_rd = 1'($urandom_range(0, 1));
      exe_b = ($urandom_range(0, 4) == 0); mem_wb = 1'($urandom_range(0, 1));
      mem_rd = ($urandom_range(0, 5) == 0); mem_wr = ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (haz[k] !== m_hazard(k)) begin errors++;
          $display("FAIL rand_hazard dut%0d i%0d: got %b expected %b", k, i, haz[k], m_hazard(k)); end
        checks++;
        if (fl[k] !== m_flush(k)) begin errors++;
          $display("FAIL rand_flush dut%0d i%0d: got %b expected %b", k, i, fl[k], m_flush(k)); end
        checks++;
        if (frz[k] !== m_freeze(k)) begin errors++;
          $display("FAIL rand_freeze dut%0d i%0d: got %b expected %b", k, i, frz[k], m_freeze(k)); end
        checks++;
        if (st[k] !== m_start(k)) begin errors++;
          $display("FAIL rand_start dut%0d i%0d: got %b expected %b", k, i, st[k], m_start(k)); end
        checks++;
        if (er[k] !== err_m[k]) begin errors++;
          $display("FAIL rand_err dut%0d i%0d: got %b expected %b", k, i, er[k], err_m[k]); end
        checks++;
        if (sc[k] !== 16'(cnt_m[k])) begin errors++;
          $display("FAIL rand_stall dut%0d i%0d: got %0d expected %0d", k, i, sc[k], cnt_m[k]); end
      end
      tick();
    end
    zero_inputs();
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_reset_mid_wait();
    zero_inputs();
    mem_rd = 1'b1; tick();
    mem_rd = 1'b0; tick();
    checks++;
    if (frz !== 2'b11 || er[0] !== 1'b1) begin errors++;
      $display("FAIL midwait_pre: got frz=%b er=%b expected 11 and er0=1", frz, er); end
    #2; rst = 1'b0; #1;
    for (int k = 0; k < 2; k++) model_reset(k);
    checks++;
    if (frz !== 2'b00 || st !== 2'b00 || er !== 2'b00 || sc !== 32'd0) begin errors++;
      $display("FAIL midwait_async_reset: got frz=%b st=%b er=%b sc=%h expected all 0", frz, st, er, sc); end
    @(negedge clk); rst = 1'b1;
    tick(); tick();
    checks++;
    if (frz !== 2'b00 || er !== 2'b00 || sc !== 32'd0) begin errors++;
      $display("FAIL midwait_after_reset: got frz=%b er=%b sc=%h expected 0", frz, er, sc); end
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_forward();
    test_latency();
    test_flush();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
